// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the serial arithmetic blocks.
//   serial_state_t : control state of a bit-serial operator (IDLE/BUSY/DONE)
//   full_sub()     : single-bit full subtractor, returns {d, bout}
// -----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } serial_state_t;

    // d = x - y - bin (one bit); bout is set when the bit result underflows.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic d;
        logic bout;
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        return {d, bout};
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// -----------------------------------------------------------------------------
// full_subtractor_cell
// Combinational single-bit subtractor cell used by the serial datapath.
// Ports:
//   x    in  minuend bit
//   y    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
// -----------------------------------------------------------------------------
module full_subtractor_cell
    import arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign {d, bout} = full_sub(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow flop.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   in_valid  in  request valid
//   in_ready  out request accepted when high (IDLE only)
//   a, b      in  unsigned operands, sampled on accept
//   out_valid out result valid (DONE only)
//   out_ready in  result consumed on out_valid && out_ready
//   diff      out (a - b) mod 2^WIDTH
//   borrow    out a < b
//   zero      out diff == 0
// -----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_subtractor: WIDTH must be >= 2");
        end
    endgenerate

    serial_state_t    state;
    serial_state_t    state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             zero_r;
    logic             d_bit;
    logic             br_nxt;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] d_sh_nxt;

    full_subtractor_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == BUSY) && (cnt == LAST);
    // Each new difference bit enters at the MSB, so after WIDTH shifts the
    // first (LSB) bit has arrived at position 0.
    assign d_sh_nxt = {d_bit, d_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            zero_r <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            d_sh   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            zero_r <= 1'b0;
        end else if (state == BUSY) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= d_sh_nxt;
            br   <= br_nxt;
            cnt  <= cnt + 1'b1;
            // Zero flag is registered alongside the final bit so it is
            // never asserted by the cleared shift register outside DONE.
            if (last_bit) begin
                zero_r <= (d_sh_nxt == '0);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = d_sh;
    assign borrow    = br;
    assign zero      = zero_r;

endmodule
